// File: rtl/mem_test_pkg.sv
// mem_test_pkg
// Shared types and constants for the burst traffic tester.
//   state_t          : tester FSM states (IDLE / WRITE / READ)
//   LFSR_POLY        : Galois tap mask for x^32 + x^22 + x^2 + x + 1
//   LFSR_SEED_PREFIX : top byte of the per-burst PRBS seed
//   ERR_CNT_MAX      : saturation value of the error counter
//   lfsr_step()      : one advance of the PRBS generator
package mem_test_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   localparam logic [31:0] LFSR_POLY        = 32'h0040_0007;
   localparam logic [7:0]  LFSR_SEED_PREFIX = 8'hA5;
   localparam logic [15:0] ERR_CNT_MAX      = 16'hFFFF;

   // Left-shifting Galois form: the bit shifted out of [31] folds back
   // into the x^22, x^2, x^1 and x^0 tap positions.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[31] ? ({s[30:0], 1'b0} ^ LFSR_POLY) : {s[30:0], 1'b0};
   endfunction

endpackage

// File: rtl/mem_test_lfsr.sv
// mem_test_lfsr
// 32-bit PRBS generator with synchronous seed load and single-step advance.
// Ports:
//   mem_clk    in  : clock
//   rst        in  : synchronous active-high reset (state -> 0)
//   load       in  : load seed (wins over advance)
//   seed       in  : 32-bit seed value
//   advance    in  : step the generator once
//   lfsr_state out : current 32-bit state
module mem_test_lfsr
   import mem_test_pkg::*;
(
   input  logic        mem_clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        advance,
   output logic [31:0] lfsr_state
);

   always_ff @(posedge mem_clk) begin
      if (rst)
         lfsr_state <= '0;
      else if (load)
         lfsr_state <= seed;
      else if (advance)
         lfsr_state <= lfsr_step(lfsr_state);
   end

endmodule

// File: rtl/mem_burst_tester.sv
// mem_burst_tester
// Write/read-back burst traffic generator and checker for the mem_burst_v2
// burst port. Writes a pattern burst, reads the same address back, checks
// every beat, then steps the address, wrapping after ADDR_LIMIT.
// Build option: define MEM_BURST_TESTER_PRBS_EN for the PRBS pattern;
// otherwise the counter pattern is used and no LFSR logic is built.
// Ports:
//   mem_clk, rst                 : phy_clk and synchronous active-high reset
//   local_init_done, enable      : controller calibrated / run traffic
//   wr_burst_req/len/addr        : write burst request
//   wr_burst_data_req/data       : write beat strobe in, write word out
//   rd_burst_req/len/addr        : read burst request
//   rd_burst_data_valid/data     : read beat strobe and word in
//   burst_finish                 : end of current burst
//   busy                         : FSM not idle
//   err, err_pulse, err_cnt      : sticky flag, per-event pulse, saturating count
//   pass_cnt                     : completed full address sweeps
module mem_burst_tester
   import mem_test_pkg::*;
#(
   parameter int                    MEM_DATA_BITS = 128,
   parameter int                    ADDR_BITS     = 24,
   parameter int                    BURST_LEN     = 128,
   parameter int                    ADDR_STEP     = 128,
   parameter logic [ADDR_BITS-1:0]  ADDR_LIMIT    = 24'hFFFF80
)(
   input  logic                     mem_clk,
   input  logic                     rst,
   input  logic                     local_init_done,
   input  logic                     enable,
   output logic                     wr_burst_req,
   output logic [9:0]               wr_burst_len,
   output logic [ADDR_BITS-1:0]     wr_burst_addr,
   input  logic                     wr_burst_data_req,
   output logic [MEM_DATA_BITS-1:0] wr_burst_data,
   output logic                     rd_burst_req,
   output logic [9:0]               rd_burst_len,
   output logic [ADDR_BITS-1:0]     rd_burst_addr,
   input  logic                     rd_burst_data_valid,
   input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
   input  logic                     burst_finish,
   output logic                     busy,
   output logic                     err,
   output logic                     err_pulse,
   output logic [15:0]              err_cnt,
   output logic [31:0]              pass_cnt
);

   localparam logic [9:0]           LEN10  = 10'(BURST_LEN);
   localparam logic [ADDR_BITS-1:0] STEP_A = ADDR_BITS'(ADDR_STEP);

   state_t                   state, state_nxt;
   logic [ADDR_BITS-1:0]     addr, addr_d;
   logic                     pass_inc;
   logic [9:0]               k;
   logic [10:0]              k_eff;
   logic [1:0]               n_ev;
   logic [MEM_DATA_BITS-1:0] exp_word;

   function automatic logic [15:0] err_sat_add(input logic [15:0] cnt, input logic [1:0] n);
      logic [16:0] sum;
      sum = {1'b0, cnt} + {15'd0, n};
      return (sum > {1'b0, ERR_CNT_MAX}) ? ERR_CNT_MAX : sum[15:0];
   endfunction

   assign wr_burst_len  = LEN10;
   assign rd_burst_len  = LEN10;
   assign wr_burst_addr = addr;
   assign rd_burst_addr = addr;
   assign busy          = (state != IDLE);

`ifdef MEM_BURST_TESTER_PRBS_EN
   logic [31:0] wr_lfsr, rd_lfsr, seed;

   // Seed from the address the new burst will use, which on READ->WRITE is
   // the stepped address being registered in the same cycle.
   assign seed = {LFSR_SEED_PREFIX, 24'(addr_d)};

   mem_test_lfsr u_wr_lfsr (
      .mem_clk    (mem_clk),
      .rst        (rst),
      .load       ((state_nxt == WRITE) && (state != WRITE)),
      .seed       (seed),
      .advance    ((state == WRITE) && wr_burst_data_req),
      .lfsr_state (wr_lfsr)
   );

   mem_test_lfsr u_rd_lfsr (
      .mem_clk    (mem_clk),
      .rst        (rst),
      .load       ((state_nxt == READ) && (state != READ)),
      .seed       (seed),
      .advance    ((state == READ) && rd_burst_data_valid),
      .lfsr_state (rd_lfsr)
   );

   assign wr_burst_data = {(MEM_DATA_BITS/32){wr_lfsr}};
   assign exp_word      = {(MEM_DATA_BITS/32){rd_lfsr}};
`else
   logic [7:0] pat_byte;

   // Read and write share addr and k, so one pattern byte serves both.
   assign pat_byte      = 8'(addr / STEP_A) + k[7:0];
   assign wr_burst_data = {(MEM_DATA_BITS/8){pat_byte}};
   assign exp_word      = {(MEM_DATA_BITS/8){pat_byte}};
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = WRITE;
         WRITE:   if (burst_finish) state_nxt = READ;
         READ:    if (burst_finish) state_nxt = enable ? WRITE : IDLE;
         default: state_nxt = IDLE;
      endcase
      if (!local_init_done)
         state_nxt = IDLE;
   end

   always_comb begin
      addr_d   = addr;
      pass_inc = 1'b0;
      if ((state == READ) && burst_finish && local_init_done) begin
         if (addr == ADDR_LIMIT) begin
            addr_d   = '0;
            pass_inc = 1'b1;
         end else begin
            addr_d = addr + STEP_A;
         end
      end
   end

   // The beat is checked before the short-burst test, so a final beat that
   // coincides with burst_finish counts towards completion.
   always_comb begin
      n_ev  = 2'd0;
      k_eff = {1'b0, k};
      if ((state == READ) && rd_burst_data_valid) begin
         if (k >= LEN10) begin
            n_ev = n_ev + 2'd1;
         end else begin
            k_eff = k_eff + 11'd1;
            if (rd_burst_data != exp_word)
               n_ev = n_ev + 2'd1;
         end
      end
      if ((state == READ) && burst_finish && (k_eff < {1'b0, LEN10}))
         n_ev = n_ev + 2'd1;
   end

   always_ff @(posedge mem_clk) begin
      if (rst) begin
         state        <= IDLE;
         addr         <= '0;
         k            <= '0;
         wr_burst_req <= 1'b0;
         rd_burst_req <= 1'b0;
         err          <= 1'b0;
         err_pulse    <= 1'b0;
         err_cnt      <= '0;
         pass_cnt     <= '0;
      end else begin
         state <= state_nxt;
         addr  <= addr_d;
         if (pass_inc)
            pass_cnt <= pass_cnt + 32'd1;

         // k restarts on every state change and stops at BURST_LEN so that
         // surplus read beats remain detectable.
         if (state_nxt != state)
            k <= '0;
         else if ((k < LEN10) && (((state == WRITE) && wr_burst_data_req) ||
                                  ((state == READ) && rd_burst_data_valid)))
            k <= k + 10'd1;

         if ((state_nxt == WRITE) && (state != WRITE))
            wr_burst_req <= 1'b1;
         else if ((state_nxt != WRITE) || wr_burst_data_req)
            wr_burst_req <= 1'b0;

         if ((state_nxt == READ) && (state != READ))
            rd_burst_req <= 1'b1;
         else if ((state_nxt != READ) || rd_burst_data_valid)
            rd_burst_req <= 1'b0;

         err_pulse <= (n_ev != 2'd0);
         if (n_ev != 2'd0) begin
            err     <= 1'b1;
            err_cnt <= err_sat_add(err_cnt, n_ev);
         end
      end
   end

endmodule

// File: tb/tb_mem_burst_tester.sv
// tb_mem_burst_tester
// Directed bench for mem_burst_tester with BURST_LEN=4, ADDR_STEP=4,
// ADDR_LIMIT=8. Tasks wr_burst/rd_burst play the mem_burst_v2 side; each
// test task checks its own results inline.
module tb_mem_burst_tester;

   logic         mem_clk = 1'b0;
   logic         rst = 1'b1;
   logic         local_init_done = 1'b0;
   logic         enable = 1'b0;
   logic         wr_burst_req;
   logic [9:0]   wr_burst_len;
   logic [23:0]  wr_burst_addr;
   logic         wr_burst_data_req = 1'b0;
   logic [127:0] wr_burst_data;
   logic         rd_burst_req;
   logic [9:0]   rd_burst_len;
   logic [23:0]  rd_burst_addr;
   logic         rd_burst_data_valid = 1'b0;
   logic [127:0] rd_burst_data = '0;
   logic         burst_finish = 1'b0;
   logic         busy;
   logic         err;
   logic         err_pulse;
   logic [15:0]  err_cnt;
   logic [31:0]  pass_cnt;

   int tests  = 0;
   int failed = 0;

   mem_burst_tester #(
      .MEM_DATA_BITS (128),
      .ADDR_BITS     (24),
      .BURST_LEN     (4),
      .ADDR_STEP     (4),
      .ADDR_LIMIT    (24'd8)
   ) dut (
      .mem_clk             (mem_clk),
      .rst                 (rst),
      .local_init_done     (local_init_done),
      .enable              (enable),
      .wr_burst_req        (wr_burst_req),
      .wr_burst_len        (wr_burst_len),
      .wr_burst_addr       (wr_burst_addr),
      .wr_burst_data_req   (wr_burst_data_req),
      .wr_burst_data       (wr_burst_data),
      .rd_burst_req        (rd_burst_req),
      .rd_burst_len        (rd_burst_len),
      .rd_burst_addr       (rd_burst_addr),
      .rd_burst_data_valid (rd_burst_data_valid),
      .rd_burst_data       (rd_burst_data),
      .burst_finish        (burst_finish),
      .busy                (busy),
      .err                 (err),
      .err_pulse           (err_pulse),
      .err_cnt             (err_cnt),
      .pass_cnt            (pass_cnt)
   );

   always #5 mem_clk = ~mem_clk;

   task automatic tick();
      @(posedge mem_clk);
      #1;
   endtask

   // Expected word k of the burst at address a.
   function automatic logic [127:0] exp_word(input logic [23:0] a, input int k);
`ifdef MEM_BURST_TESTER_PRBS_EN
      logic [31:0] s;
      s = {8'hA5, a};
      for (int i = 0; i < k; i++)
         s = s[31] ? ({s[30:0], 1'b0} ^ 32'h0040_0007) : {s[30:0], 1'b0};
      return {4{s}};
`else
      logic [23:0] q;
      logic [7:0]  b;
      q = a / 24'd4;
      b = q[7:0] + 8'(k);
      return {16{b}};
`endif
   endfunction

   // Accepts one 4-beat write burst; counts beats whose data differs.
   task automatic wr_burst(input int clr_en_beat, output int bad, output logic [127:0] w0,
                           output logic [23:0] a, output bit tmo);
      int n;
      bad = 0; w0 = '0; a = '0; tmo = 1'b0; n = 0;
      while (wr_burst_req !== 1'b1 && n < 20) begin tick(); n++; end
      if (wr_burst_req !== 1'b1) begin tmo = 1'b1; return; end
      a = wr_burst_addr;
      for (int k = 0; k < 4; k++) begin
         wr_burst_data_req = 1'b1;
         if (k == clr_en_beat) enable = 1'b0;
         if (k == 0) w0 = wr_burst_data;
         if (wr_burst_data !== exp_word(a, k)) bad++;
         tick();
      end
      wr_burst_data_req = 1'b0;
      burst_finish = 1'b1;
      tick();
      burst_finish = 1'b0;
   endtask

   // Returns nbeats read beats (beat 'corrupt' with bit 0 flipped); records
   // err_pulse occurrences and the beat (nbeats = the finish cycle) they follow.
   task automatic rd_burst(input int nbeats, input int corrupt, input bit fin_last,
                           output int npulse, output int pulse_at,
                           output logic [23:0] a, output bit tmo);
      int n;
      npulse = 0; pulse_at = -1; a = '0; tmo = 1'b0; n = 0;
      while (rd_burst_req !== 1'b1 && n < 20) begin tick(); n++; end
      if (rd_burst_req !== 1'b1) begin tmo = 1'b1; return; end
      a = rd_burst_addr;
      for (int k = 0; k < nbeats; k++) begin
         rd_burst_data_valid = 1'b1;
         rd_burst_data = exp_word(a, k) ^ ((k == corrupt) ? 128'd1 : 128'd0);
         if (fin_last && k == nbeats - 1) burst_finish = 1'b1;
         tick();
         if (err_pulse === 1'b1) begin npulse++; pulse_at = k; end
      end
      rd_burst_data_valid = 1'b0;
      rd_burst_data = '0;
      if (!fin_last) begin
         burst_finish = 1'b1;
         tick();
         if (err_pulse === 1'b1) begin npulse++; pulse_at = nbeats; end
      end
      burst_finish = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      tests++; if (wr_burst_req !== 1'b0) begin failed++; $display("FAIL reset_wr_req: got %b want 0", wr_burst_req); end
      tests++; if (rd_burst_req !== 1'b0) begin failed++; $display("FAIL reset_rd_req: got %b want 0", rd_burst_req); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (err !== 1'b0 || err_pulse !== 1'b0) begin failed++; $display("FAIL reset_err: got %b/%b want 0/0", err, err_pulse); end
      tests++; if (err_cnt !== 16'd0) begin failed++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
      tests++; if (pass_cnt !== 32'd0) begin failed++; $display("FAIL reset_pass_cnt: got %0d want 0", pass_cnt); end
      tests++; if (wr_burst_addr !== 24'd0 || rd_burst_addr !== 24'd0) begin failed++; $display("FAIL reset_addr: got %h/%h want 0", wr_burst_addr, rd_burst_addr); end
      tests++; if (wr_burst_data !== 128'd0) begin failed++; $display("FAIL reset_wr_data: got %h want 0", wr_burst_data); end
      tests++; if (wr_burst_len !== 10'd4 || rd_burst_len !== 10'd4) begin failed++; $display("FAIL burst_len: got %0d/%0d want 4", wr_burst_len, rd_burst_len); end
      rst = 1'b0;
      tick();
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL idle_no_init: busy got %b want 0", busy); end
   endtask

   task automatic test_sweep();
      int bad, np, pat;
      logic [127:0] w0;
      logic [23:0] wa, ra;
      bit t1, t2;
      local_init_done = 1'b1;
      enable = 1'b1;
      for (int p = 0; p < 3; p++) begin
         wr_burst(-1, bad, w0, wa, t1);
         rd_burst(4, -1, 1'b0, np, pat, ra, t2);
         tests++; if (t1 || t2) begin failed++; $display("FAIL sweep_timeout pair %0d: got %b%b want 00", p, t1, t2); end
         tests++; if (wa !== 24'(p * 4)) begin failed++; $display("FAIL sweep_addr pair %0d: got %0d want %0d", p, wa, p * 4); end
         tests++; if (ra !== wa) begin failed++; $display("FAIL sweep_rd_addr pair %0d: got %0d want %0d", p, ra, wa); end
         tests++; if (bad !== 0) begin failed++; $display("FAIL sweep_wr_data pair %0d: %0d bad beats want 0", p, bad); end
         tests++; if (np !== 0) begin failed++; $display("FAIL sweep_rd_check pair %0d: %0d pulses want 0", p, np); end
`ifdef MEM_BURST_TESTER_PRBS_EN
         if (p == 0) begin
            tests++; if (w0 !== {4{32'hA500_0000}}) begin failed++; $display("FAIL prbs_word0: got %h want a5000000 x4", w0); end
         end
`else
         if (p == 1) begin
            tests++; if (w0 !== {16{8'h01}}) begin failed++; $display("FAIL counter_word0_addr4: got %h want 01 x16", w0); end
         end
`endif
      end
      tests++; if (pass_cnt !== 32'd1) begin failed++; $display("FAIL sweep_pass_cnt: got %0d want 1", pass_cnt); end
      tests++; if (wr_burst_addr !== 24'd0) begin failed++; $display("FAIL sweep_wrap: got %0d want 0", wr_burst_addr); end
      tests++; if (err_cnt !== 16'd0 || err !== 1'b0) begin failed++; $display("FAIL sweep_no_err: got %0d/%b want 0/0", err_cnt, err); end
   endtask

   task automatic test_corrupt_beat();
      int bad, np, pat;
      logic [127:0] w0;
      logic [23:0] wa, ra;
      bit t1, t2;
      wr_burst(-1, bad, w0, wa, t1);
      rd_burst(4, 2, 1'b0, np, pat, ra, t2);
      tests++; if (t1 || t2) begin failed++; $display("FAIL corrupt_timeout: got %b%b want 00", t1, t2); end
      tests++; if (np !== 1 || pat !== 2) begin failed++; $display("FAIL corrupt_pulse: got %0d pulses after beat %0d want 1 after beat 2", np, pat); end
      tests++; if (err !== 1'b1) begin failed++; $display("FAIL corrupt_err: got %b want 1", err); end
      tests++; if (err_cnt !== 16'd1) begin failed++; $display("FAIL corrupt_err_cnt: got %0d want 1", err_cnt); end
   endtask

   task automatic test_short_burst();
      int bad, np, pat;
      logic [127:0] w0;
      logic [23:0] wa, ra;
      bit t1, t2;
      wr_burst(-1, bad, w0, wa, t1);
      rd_burst(3, -1, 1'b0, np, pat, ra, t2);
      tests++; if (t1 || t2) begin failed++; $display("FAIL short_timeout: got %b%b want 00", t1, t2); end
      tests++; if (wa !== 24'd4) begin failed++; $display("FAIL short_addr: got %0d want 4", wa); end
      tests++; if (np !== 1 || pat !== 3) begin failed++; $display("FAIL short_pulse: got %0d pulses at %0d want 1 at finish", np, pat); end
      tests++; if (err_cnt !== 16'd2) begin failed++; $display("FAIL short_err_cnt: got %0d want 2", err_cnt); end
   endtask

   task automatic test_extra_beat();
      int bad, np, pat;
      logic [127:0] w0;
      logic [23:0] wa, ra;
      bit t1, t2;
      wr_burst(-1, bad, w0, wa, t1);
      rd_burst(5, -1, 1'b0, np, pat, ra, t2);
      tests++; if (t1 || t2) begin failed++; $display("FAIL extra_timeout: got %b%b want 00", t1, t2); end
      tests++; if (np !== 1 || pat !== 4) begin failed++; $display("FAIL extra_pulse: got %0d pulses after beat %0d want 1 after beat 4", np, pat); end
      tests++; if (err_cnt !== 16'd3) begin failed++; $display("FAIL extra_err_cnt: got %0d want 3", err_cnt); end
      tests++; if (pass_cnt !== 32'd2 || wr_burst_addr !== 24'd0) begin failed++; $display("FAIL extra_wrap: got pass %0d addr %0d want 2/0", pass_cnt, wr_burst_addr); end
   endtask

   task automatic test_back_to_back();
      int bad, np, pat;
      logic [127:0] w0;
      logic [23:0] wa, ra;
      bit t1, t2;
      wr_burst(-1, bad, w0, wa, t1);
      rd_burst(4, -1, 1'b1, np, pat, ra, t2);
      tests++; if (t1 || t2) begin failed++; $display("FAIL b2b_timeout: got %b%b want 00", t1, t2); end
      tests++; if (np !== 0) begin failed++; $display("FAIL b2b_finish_with_last: got %0d pulses want 0", np); end
      tests++; if (err_cnt !== 16'd3) begin failed++; $display("FAIL b2b_err_cnt: got %0d want 3", err_cnt); end
      tests++; if (wr_burst_addr !== 24'd4) begin failed++; $display("FAIL b2b_addr_step: got %0d want 4", wr_burst_addr); end
   endtask

   task automatic test_init_drop();
      tests++; if (wr_burst_req !== 1'b1 || busy !== 1'b1) begin failed++; $display("FAIL init_drop_pre: req %b busy %b want 1/1", wr_burst_req, busy); end
      local_init_done = 1'b0;
      tick();
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL init_drop_busy: got %b want 0", busy); end
      tests++; if (wr_burst_req !== 1'b0 || rd_burst_req !== 1'b0) begin failed++; $display("FAIL init_drop_req: got %b/%b want 0/0", wr_burst_req, rd_burst_req); end
      tests++; if (wr_burst_addr !== 24'd4 || err_cnt !== 16'd3 || pass_cnt !== 32'd2) begin failed++; $display("FAIL init_drop_kept: got addr %0d err %0d pass %0d want 4/3/2", wr_burst_addr, err_cnt, pass_cnt); end
      tick();
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL init_low_hold: busy got %b want 0", busy); end
      local_init_done = 1'b1;
   endtask

   task automatic test_enable_low();
      int bad, np, pat;
      logic [127:0] w0;
      logic [23:0] wa, ra;
      bit t1, t2;
      wr_burst(1, bad, w0, wa, t1);
      rd_burst(4, -1, 1'b0, np, pat, ra, t2);
      tests++; if (t1 || t2) begin failed++; $display("FAIL en_low_timeout: got %b%b want 00", t1, t2); end
      tests++; if (wa !== 24'd4 || bad !== 0 || np !== 0) begin failed++; $display("FAIL en_low_bursts: addr %0d bad %0d pulses %0d want 4/0/0", wa, bad, np); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL en_low_idle: busy got %b want 0", busy); end
      tests++; if (wr_burst_addr !== 24'd8) begin failed++; $display("FAIL en_low_addr: got %0d want 8", wr_burst_addr); end
      repeat (3) tick();
      tests++; if (busy !== 1'b0 || wr_burst_req !== 1'b0 || rd_burst_req !== 1'b0) begin failed++; $display("FAIL en_low_stay: busy %b req %b/%b want 0", busy, wr_burst_req, rd_burst_req); end
   endtask

   task automatic test_rst_mid_read();
      int bad, n;
      logic [127:0] w0;
      logic [23:0] wa;
      bit t1;
      enable = 1'b1;
      wr_burst(-1, bad, w0, wa, t1);
      tests++; if (t1 || wa !== 24'd8) begin failed++; $display("FAIL rst_pre_write: tmo %b addr %0d want 0/8", t1, wa); end
      n = 0;
      while (rd_burst_req !== 1'b1 && n < 20) begin tick(); n++; end
      tests++; if (rd_burst_req !== 1'b1) begin failed++; $display("FAIL rst_pre_read: rd_req got %b want 1", rd_burst_req); end
      rd_burst_data_valid = 1'b1;
      rd_burst_data = exp_word(24'd8, 0);
      tick();
      rd_burst_data = exp_word(24'd8, 1) ^ 128'd1;
      rst = 1'b1;
      enable = 1'b0;
      tick();
      rd_burst_data_valid = 1'b0;
      rd_burst_data = '0;
      tests++; if (wr_burst_req !== 1'b0 || rd_burst_req !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL rst_mid_ctrl: req %b/%b busy %b want 0", wr_burst_req, rd_burst_req, busy); end
      tests++; if (err !== 1'b0 || err_pulse !== 1'b0 || err_cnt !== 16'd0) begin failed++; $display("FAIL rst_mid_err: %b/%b/%0d want 0", err, err_pulse, err_cnt); end
      tests++; if (pass_cnt !== 32'd0 || wr_burst_addr !== 24'd0 || rd_burst_addr !== 24'd0) begin failed++; $display("FAIL rst_mid_cnt: pass %0d addr %0d/%0d want 0", pass_cnt, wr_burst_addr, rd_burst_addr); end
      tests++; if (wr_burst_data !== 128'd0) begin failed++; $display("FAIL rst_mid_data: got %h want 0", wr_burst_data); end
      rst = 1'b0;
      tick();
      tests++; if (err_pulse !== 1'b0 || err_cnt !== 16'd0 || busy !== 1'b0) begin failed++; $display("FAIL rst_priority: pulse %b cnt %0d busy %b want 0", err_pulse, err_cnt, busy); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sweep();
      test_corrupt_beat();
      test_short_burst();
      test_extra_beat();
      test_back_to_back();
      test_init_drop();
      test_enable_low();
      test_rst_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
